// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - main-memory stage with MAR/MDR, wait-state timer and four-phase MFC handshake
module memory_unit #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              MAR_address_in_en,
   input  logic              MDR_bus_data_in_en,
   input  logic              EN,
   input  logic              R_W,
   output logic              MFC,
   input  logic              MDR_bus_data_out_en,
   output logic [DATA_W-1:0] bus_out,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic [3:0]        wait_cnt;
   logic              op_read;
   logic              mfc;
   logic              do_access;

   logic [DATA_W-1:0] mem [DEPTH];

   // State is forced to IDLE while reset is low, so an aborted write never reaches the array.
   assign do_access = (state == ACCESS) && (wait_cnt == 4'd0);

   always_ff @(posedge clock) begin
      if (do_access && !op_read)
         mem[mar] <= mdr;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mar      <= '0;
         mdr      <= '0;
         wait_cnt <= 4'd0;
         op_read  <= 1'b1;
         mfc      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MAR_address_in_en)
                  mar <= bus_in[ADDR_W-1:0];
               if (MDR_bus_data_in_en)
                  mdr <= bus_in;
               if (EN) begin
                  op_read  <= R_W;
                  wait_cnt <= WAIT_INIT;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  if (op_read)
                     mdr <= mem[mar];
                  mfc   <= 1'b1;
                  state <= COMPLETE;
               end
            end
            COMPLETE: begin
               if (!EN) begin
                  mfc   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MFC     = mfc;
   assign busy    = (state != IDLE);
   assign bus_out = MDR_bus_data_out_en ? mdr : '0;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - scoreboard bench driving a 2-wait and a 0-wait memory_unit in lockstep
module tb_memory_unit;

   typedef struct {
      int          lat;
      logic [15:0] data;
      int          accept;
      string       nm;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] bus_in;
   logic        mar_en, mdr_en, en, r_w, out_en;
   logic        mfc_a, mfc_b, busy_a, busy_b;
   logic [15:0] bus_out_a, bus_out_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   memory_unit #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_a (
      .clock(clock), .reset(reset), .bus_in(bus_in),
      .MAR_address_in_en(mar_en), .MDR_bus_data_in_en(mdr_en),
      .EN(en), .R_W(r_w), .MFC(mfc_a),
      .MDR_bus_data_out_en(out_en), .bus_out(bus_out_a), .busy(busy_a)
   );

   memory_unit #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_b (
      .clock(clock), .reset(reset), .bus_in(bus_in),
      .MAR_address_in_en(mar_en), .MDR_bus_data_in_en(mdr_en),
      .EN(en), .R_W(r_w), .MFC(mfc_b),
      .MDR_bus_data_out_en(out_en), .bus_out(bus_out_b), .busy(busy_b)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitors: pop one expectation per rising MFC and check latency and returned data.
   always @(negedge clock) begin
      if (mfc_a && !prev_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_mfc actual=1 required=0 at cycle %0d", cyc);
         end else begin
            e_a = q_a.pop_front();
            chk({e_a.nm, "_lat_a"}, cyc - e_a.accept, e_a.lat);
            chk({e_a.nm, "_data_a"}, {16'h0, bus_out_a}, {16'h0, e_a.data});
         end
      end
      prev_a <= mfc_a;
   end

   always @(negedge clock) begin
      if (mfc_b && !prev_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_mfc actual=1 required=0 at cycle %0d", cyc);
         end else begin
            e_b = q_b.pop_front();
            chk({e_b.nm, "_lat_b"}, cyc - e_b.accept, e_b.lat);
            chk({e_b.nm, "_data_b"}, {16'h0, bus_out_b}, {16'h0, e_b.data});
         end
      end
      prev_b <= mfc_b;
   end

   task automatic load_mar(input logic [15:0] v);
      bus_in = v; mar_en = 1'b1;
      @(posedge clock); #1;
      mar_en = 1'b0;
   endtask

   task automatic load_mdr(input logic [15:0] v);
      bus_in = v; mdr_en = 1'b1;
      @(posedge clock); #1;
      mdr_en = 1'b0;
   endtask

   task automatic acc(input logic rw, input logic sim_mar, input logic [15:0] mar_val,
                      input logic disturb, input logic [15:0] exp_a, input logic [15:0] exp_b,
                      input string nm);
      exp_t e;
      int   n;
      e.accept = cyc + 1; e.nm = nm;
      e.lat = 3; e.data = exp_a; q_a.push_back(e);
      e.lat = 1; e.data = exp_b; q_b.push_back(e);
      en = 1'b1; r_w = rw;
      if (sim_mar) begin
         mar_en = 1'b1; bus_in = mar_val;
      end
      @(posedge clock); #1;
      mar_en = 1'b0;
      if (disturb) begin
         mar_en = 1'b1; bus_in = 16'h0033; r_w = ~rw;
         @(posedge clock); #1;
         mar_en = 1'b0;
      end
      n = 0;
      while (!mfc_a && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk({nm, "_mfc_a"}, mfc_a, 1);
      chk({nm, "_mfc_b"}, mfc_b, 1);
      @(posedge clock); #1;
      chk({nm, "_hold_a"}, mfc_a, 1);
      en = 1'b0;
      @(posedge clock); #1;
      chk({nm, "_drop_a"}, mfc_a, 0);
      chk({nm, "_drop_b"}, mfc_b, 0);
      chk({nm, "_idle_a"}, busy_a, 0);
      chk({nm, "_idle_b"}, busy_b, 0);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string nm);
      load_mar(addr);
      load_mdr(data);
      acc(1'b0, 1'b0, 16'h0, 1'b0, data, data, nm);
   endtask

   initial begin
      exp_t e;
      reset = 1'b0; en = 1'b1; r_w = 1'b1; bus_in = 16'h0;
      mar_en = 1'b0; mdr_en = 1'b0; out_en = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_mfc_a", mfc_a, 0);
      chk("rst_mfc_b", mfc_b, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_bus_a", bus_out_a, 0);
      chk("rst_bus_b", bus_out_b, 0);
      en = 1'b0; reset = 1'b1;
      @(posedge clock); #1;

      wr(16'h0010, 16'hBEEF, "wr10");
      load_mdr(16'h0000);
      chk("mdr_clear_a", bus_out_a, 0);
      load_mar(16'h0010);
      acc(1'b1, 1'b0, 16'h0, 1'b0, 16'hBEEF, 16'hBEEF, "rd10");

      wr(16'h0022, 16'h1234, "wr22");
      load_mar(16'h0010);
      load_mdr(16'h0000);
      acc(1'b1, 1'b1, 16'h0022, 1'b0, 16'h1234, 16'h1234, "rd22_sim");

      wr(16'h0033, 16'h3333, "wr33");
      load_mar(16'h0022);
      load_mdr(16'h0000);
      acc(1'b1, 1'b0, 16'h0, 1'b1, 16'h1234, 16'h1234, "rd22_dist");
      load_mdr(16'h0000);
      acc(1'b1, 1'b0, 16'h0, 1'b0, 16'h1234, 16'h1234, "rd22_again");

      out_en = 1'b0;
      #1;
      chk("gate_a", bus_out_a, 0);
      chk("gate_b", bus_out_b, 0);
      out_en = 1'b1;
      #1;
      chk("ungate_a", bus_out_a, 16'h1234);

      wr(16'h0005, 16'h0505, "wr05");
      load_mdr(16'h0000);
      load_mar(16'hFF05);
      acc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0505, 16'h0505, "rd_wrap");

      wr(16'h0040, 16'h5555, "wr40");
      load_mdr(16'hAAAA);
      load_mar(16'h0040);
      e.accept = cyc + 1; e.nm = "abort_b"; e.lat = 1; e.data = 16'hAAAA;
      q_b.push_back(e);
      en = 1'b1; r_w = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("abort_busy_a", busy_a, 1);
      chk("abort_mfc_b_pre", mfc_b, 1);
      reset = 1'b0; en = 1'b0;
      #1;
      chk("abort_mfc_b", mfc_b, 0);
      chk("abort_busy_a_rst", busy_a, 0);
      chk("abort_busy_b_rst", busy_b, 0);
      @(posedge clock); #1;
      chk("abort_mfc_a", mfc_a, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      load_mar(16'h0040);
      acc(1'b1, 1'b0, 16'h0, 1'b0, 16'h5555, 16'hAAAA, "rd40_after");

      @(negedge clock); #1;
      chk("q_a_empty", q_a.size(), 0);
      chk("q_b_empty", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Main-memory stage directly upstream of the instruction-fetch controller.
- Owns MAR, MDR and a synchronous RAM array. Services EN/R_W requests from fetch and execute controllers after a programmable number of wait states, then raises MFC (memory function complete).
- Returns read data to the shared bus when MDR_bus_data_out_en is asserted.
- Handshake is four-phase: EN high, MFC high, EN low, MFC low.

Parameters:
DATA_W, 16, width of bus, MDR and memory words
ADDR_W, 8, width of MAR; memory depth = 2**ADDR_W words
WAIT_CYCLES, 2, wait states between request acceptance and completion (0..15)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
bus_in  input  DATA_W  shared data bus into the block
MAR_address_in_en  input  1  load MAR from bus_in[ADDR_W-1:0]
MDR_bus_data_in_en  input  1  load MDR from bus_in (write data)
EN  input  1  memory request strobe, level held until MFC seen
R_W  input  1  1 = read, 0 = write; sampled with EN
MFC  output  1  memory function complete, registered
MDR_bus_data_out_en  input  1  drive MDR onto bus_out
bus_out  output  DATA_W  MDR when MDR_bus_data_out_en is 1, else all zeros (combinational)
busy  output  1  high in ACCESS and COMPLETE states

Behaviour:
- Reset (reset=0, async): state=IDLE; MAR=0; MDR=0; wait counter=0; latched op=read; MFC=0; busy=0. Memory array contents are not reset.
- IDLE:
  - MAR_address_in_en and MDR_bus_data_in_en load at the clock edge.
  - EN=1 at an edge: latch R_W into op, load counter with WAIT_CYCLES, go to ACCESS.
  - Simultaneous MAR/MDR load and EN in IDLE: the newly loaded values are used by the access.
- ACCESS:
  - If counter != 0: decrement.
  - If counter == 0: perform the access at that edge and go to COMPLETE with MFC<=1.
    - Read: MDR <= mem[MAR].
    - Write: mem[MAR] <= MDR.
  - MAR/MDR load enables are ignored. EN dropping early is ignored; the access still completes.
  - R_W changes are ignored after acceptance.
- COMPLETE:
  - MFC held at 1 while EN=1.
  - EN=0 at an edge: MFC<=0, go to IDLE.
  - A new request needs EN low for at least one edge first; no back-to-back without the handshake return.
- Latency: EN sampled at edge 0, MFC first high after edge WAIT_CYCLES+1. For WAIT_CYCLES=0, MFC rises after edge 1.
- MDR output: bus_out reflects MDR in any state when MDR_bus_data_out_en=1, including during ACCESS (stale MDR).
- Address wrap: MAR is exactly ADDR_W bits. Upper bits of bus_in are discarded on MAR load.
- Reset mid-operation:
  - An aborted write in ACCESS leaves memory unchanged.
  - MFC drops immediately (asynchronously).
  - FSM restarts in IDLE when reset deasserts.
- busy is derived from state and is never high in IDLE.

Test Plan:
- Reset check: reset=0 for 2 cycles with EN=1 → MFC=0, busy=0, bus_out=0 (with MDR_bus_data_out_en=1), state IDLE.
- Write then read, WAIT_CYCLES=2:
  - Load MAR=0x10, MDR=0xBEEF, EN=1, R_W=0 → MFC rises after edge 3 and holds until EN drops; drops one edge later.
  - Clear MDR via bus_in=0x0000, then MAR=0x10, EN=1, R_W=1 → after MFC, bus_out=0xBEEF with MDR_bus_data_out_en=1.
- Simultaneous load and request: MAR_address_in_en=1 with bus_in=0x0022 in the same cycle as EN=1, R_W=1, location 0x22 preloaded with 0x1234 → MDR=0x1234 at MFC.
- Busy ignores:
  - MAR load of 0x33 during ACCESS → access uses the original MAR; MAR is unchanged after completion.
  - R_W toggled during ACCESS → op unchanged.
- Wrap and zero wait:
  - WAIT_CYCLES=0 instance: EN sampled at edge 0 → MFC high after edge 1.
  - bus_in=0xFF05 loaded to MAR (ADDR_W=8) → access hits address 0x05.
- Reset mid-access: reset=0 during ACCESS of a write of 0xAAAA to 0x40 that previously held 0x5555 → MFC=0 immediately; read of 0x40 after release returns 0x5555.
